// File: rtl/awgn_noise_adder.sv
// Adds scaled AWGN from a two-sample-per-cycle generator to a streaming signal.
// Optional saturation counter: define AWGN_SAT_CNT_EN to enable sat_cnt.
module awgn_noise_adder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WARMUP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] x0,
    input  logic [15:0] x1,
    input  logic [15:0] scale,
    input  logic        flush,
    input  logic [15:0] sig_in,
    input  logic        sig_valid,
    output logic        sig_ready,
    output logic [15:0] y_out,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [15:0] drop_cnt,
    output logic [15:0] sat_cnt
);

    localparam int unsigned DW     = 16;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int unsigned PROD_W = 33;
    localparam int unsigned SHF_W  = 18;
    localparam int unsigned SUM_W  = 19;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic [DW-1:0]       mem_d [DEPTH];
    logic [DW-1:0]       y_out_q, y_out_d;
    logic                y_valid_q, y_valid_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                push_c;
    logic                drop_c;
    logic                xfer_c;
    logic                sig_ready_c;
    logic signed [DW-1:0]     noise_c;
    logic signed [DW:0]       scale_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [SHF_W-1:0]  shift_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [DW-1:0]            y_sat_c;

    // Modular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       step);
        logic [PTR_W+1:0] tmp;
        tmp = (PTR_W+2)'(ptr) + (PTR_W+2)'(step);
        if (tmp >= (PTR_W+2)'(DEPTH)) begin
            tmp = tmp - (PTR_W+2)'(DEPTH);
        end
        return PTR_W'(tmp);
    endfunction

    // Handshake and FIFO admission decisions, all from start-of-cycle state.
    always_comb begin
        sig_ready_c = (count_q != '0) && (!y_valid_q || y_ready);
        xfer_c      = sig_valid && sig_ready_c && !flush;
        push_c      = (state_q == ST_RUN) && !flush && (count_q <= CNT_W'(DEPTH - 2));
        drop_c      = (state_q == ST_RUN) && !flush && (count_q >  CNT_W'(DEPTH - 2));
    end

    // Noise scaling: exact 33-bit product, arithmetic shift gives floor division.
    always_comb begin
        noise_c = $signed(mem_q[rd_ptr_q]);
        scale_c = $signed({1'b0, scale});
        prod_c  = PROD_W'(noise_c) * PROD_W'(scale_c);
        shift_c = SHF_W'(prod_c >>> 15);
        sum_c   = SUM_W'($signed(sig_in)) + SUM_W'(shift_c);
        if (sum_c > 19'sd32767) begin
            y_sat_c = 16'h7FFF;
        end else if (sum_c < -19'sd32768) begin
            y_sat_c = 16'h8000;
        end else begin
            y_sat_c = sum_c[DW-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        y_out_d    = y_out_q;
        y_valid_d  = y_valid_q;
        drop_cnt_d = drop_cnt_q;

        if (state_q == ST_WARM) begin
            if ((WARMUP == 0) || (warm_cnt_q >= WCNT_W'(WARMUP - 1))) begin
                state_d = ST_RUN;
            end else begin
                warm_cnt_d = warm_cnt_q + WCNT_W'(1);
            end
        end

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // Pairs are written at even addresses, so the second slot never wraps.
            if (push_c) begin
                mem_d[wr_ptr_q]                 = x0;
                mem_d[ptr_add(wr_ptr_q, 2'd1)]  = x1;
                wr_ptr_d                        = ptr_add(wr_ptr_q, 2'd2);
            end
            if (xfer_c) begin
                rd_ptr_d = ptr_add(rd_ptr_q, 2'd1);
            end
            count_d = count_q + (push_c ? CNT_W'(2) : CNT_W'(0))
                              - (xfer_c ? CNT_W'(1) : CNT_W'(0));
        end

        if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        if (xfer_c) begin
            y_out_d   = y_sat_c;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_WARM;
            warm_cnt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            y_out_q    <= '0;
            y_valid_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            y_out_q    <= y_out_d;
            y_valid_q  <= y_valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Sample storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef AWGN_SAT_CNT_EN
    logic        sat_hit_c;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_hit_c = (sum_c > 19'sd32767) || (sum_c < -19'sd32768);
        sat_cnt_d = sat_cnt_q;
        if (xfer_c && sat_hit_c && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

    assign sig_ready = sig_ready_c;
    assign y_out     = y_out_q;
    assign y_valid   = y_valid_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_awgn_noise_adder.sv
// Directed bench for awgn_noise_adder: warm-up, scaling, saturation, backpressure, flush, reset abort.
module tb_awgn_noise_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x0, x1, scale, sig_in;
    logic        flush, sig_valid, y_ready;
    logic        sig_ready, y_valid;
    logic [15:0] y_out, drop_cnt, sat_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [15:0] exp_sat;

    awgn_noise_adder #(.DEPTH(8), .WARMUP(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .x0        (x0),
        .x1        (x1),
        .scale     (scale),
        .flush     (flush),
        .sig_in    (sig_in),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .drop_cnt  (drop_cnt),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        x0        = 16'h0010;
        x1        = 16'h0020;
        scale     = 16'h0000;
        sig_in    = 16'h0000;
        flush     = 1'b0;
        sig_valid = 1'b0;
        y_ready   = 1'b1;
        tick(); tick(); tick();
        chk("rst_y_out",    y_out,            16'h0000);
        chk("rst_y_valid",  16'(y_valid),     16'h0000);
        chk("rst_sig_rdy",  16'(sig_ready),   16'h0000);
        chk("rst_drop",     drop_cnt,         16'h0000);
        chk("rst_sat",      sat_cnt,          16'h0000);

        // Release between edges; edge k below is the k-th rising edge after release.
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("warm_empty_e%0d", k), 16'(sig_ready), 16'h0000);
        end
        // Edges 17..26: pushes at 17..20 fill to 8, then one drop per edge.
        for (int k = 17; k <= 26; k++) begin
            tick();
            if (k == 17) chk("first_push_rdy", 16'(sig_ready), 16'h0001);
            chk($sformatf("drop_e%0d", k), drop_cnt, (k > 20) ? 16'(k - 20) : 16'h0000);
        end

        // Flush with full FIFO: count to 0, no drop counted.
        flush = 1'b1;
        tick();
        chk("flush_empty",  16'(sig_ready), 16'h0000);
        chk("flush_drop",   drop_cnt,       16'd6);
        chk("flush_yv",     16'(y_valid),   16'h0000);

        // Load FIFO head with 2000 then -3.
        flush  = 1'b0;
        x0     = 16'd2000;
        x1     = 16'hFFFD;
        scale  = 16'h4000;
        tick();
        chk("load_rdy", 16'(sig_ready), 16'h0001);

        // n=2000, scale=0.5, sig=1000 -> 2000.
        x0        = 16'd1000;
        x1        = 16'd1000;
        sig_in    = 16'd1000;
        sig_valid = 1'b1;
        tick();
        chk("half_scale_y", y_out,          16'd2000);
        chk("half_scale_v", 16'(y_valid),   16'h0001);

        // Back-to-back: n=-3, scale=0.5, sig=0 -> floor(-1.5) = -2.
        sig_in = 16'd0;
        tick();
        chk("floor_neg_y",  y_out,          16'hFFFE);
        chk("floor_neg_v",  16'(y_valid),   16'h0001);

        // n=1000, scale=1.0, sig=32000 -> clamps to 32767.
        scale  = 16'h8000;
        sig_in = 16'd32000;
        tick();
        chk("sat_y", y_out, 16'h7FFF);
`ifdef AWGN_SAT_CNT_EN
        exp_sat = 16'd1;
`else
        exp_sat = 16'd0;
`endif
        chk("sat_cnt", sat_cnt, exp_sat);

        // Backpressure: output held, no acceptance.
        y_ready = 1'b0;
        sig_in  = 16'd5;
        #1;
        chk("bp_sig_rdy", 16'(sig_ready), 16'h0000);
        tick();
        chk("bp_hold_y",  y_out,          16'h7FFF);
        chk("bp_hold_v",  16'(y_valid),   16'h0001);
        chk("bp_drop0",   drop_cnt,       16'd6);
        tick();
        chk("bp_hold_y2", y_out,          16'h7FFF);
        chk("bp_drop1",   drop_cnt,       16'd7);

        // Ready with nothing offered: y_valid clears, y_out held.
        y_ready   = 1'b1;
        sig_valid = 1'b0;
        tick();
        chk("drain_v",    16'(y_valid),   16'h0000);
        chk("drain_y",    y_out,          16'h7FFF);
        chk("drain_drop", drop_cnt,       16'd8);

        // Transfer while full: pop does not rescue the pair, still a drop.
        scale     = 16'h0000;
        sig_in    = 16'd123;
        sig_valid = 1'b1;
        tick();
        chk("full_xfer_y",    y_out,    16'd123);
        chk("full_xfer_drop", drop_cnt, 16'd9);

        // Flush while output pending: output untouched.
        sig_valid = 1'b0;
        y_ready   = 1'b0;
        flush     = 1'b1;
        tick();
        chk("flush_pend_v",    16'(y_valid), 16'h0001);
        chk("flush_pend_y",    y_out,        16'd123);
        chk("flush_pend_drop", drop_cnt,     16'd9);
        flush   = 1'b0;
        y_ready = 1'b1;
        #1;
        chk("empty_no_rdy", 16'(sig_ready), 16'h0000);
        tick();
        chk("refill_rdy", 16'(sig_ready), 16'h0001);
        chk("refill_v",   16'(y_valid),   16'h0000);

        // Transfer then reset mid-cycle: everything cleared immediately.
        sig_in    = 16'd7;
        sig_valid = 1'b1;
        tick();
        chk("pre_rst_y", y_out, 16'd7);
        reset = 1'b0;
        #1;
        chk("abort_v",    16'(y_valid),   16'h0000);
        chk("abort_y",    y_out,          16'h0000);
        chk("abort_rdy",  16'(sig_ready), 16'h0000);
        chk("abort_drop", drop_cnt,       16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/awgn_noise_adder.md
AWGN_NOISE_ADDER -- requirements
Module: awgn_noise_adder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, setting noise FIFO depth in 16-bit entries (even, >=4).
REQ-002 The block SHALL have parameter WARMUP, default 16, setting the number of cycles after reset release before generator samples are accepted.
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have ports x0 and x1, input, 16 bits each, signed AWGN samples from the generator, one new pair per cycle.
REQ-006 The block SHALL have port scale, input, 16 bits, unsigned noise gain in Q1.15 (0x8000 = 1.0).
REQ-007 The block SHALL have port flush, input, 1 bit, a synchronous FIFO clear.
REQ-008 The block SHALL have ports sig_in (input, 16 bits, signed signal sample), sig_valid (input, 1 bit) and sig_ready (output, 1 bit).
REQ-009 The block SHALL have ports y_out (output, 16 bits, signed noisy sample), y_valid (output, 1 bit) and y_ready (input, 1 bit).
REQ-010 The block SHALL have port drop_cnt, output, 16 bits, counting dropped generator pairs.
REQ-011 The block SHALL have port sat_cnt, output, 16 bits, counting saturated outputs.

Function
REQ-012 The block SHALL implement states WARM and RUN: WARM on reset, then RUN after WARMUP cycles counted from reset release; RUN is held until the next reset.
REQ-013 In WARM the block SHALL NOT push any samples to the FIFO.
REQ-014 In RUN, if the FIFO count at the start of the cycle is <= DEPTH-2, the block SHALL push x0 then x1 (x0 popped first).
REQ-015 In RUN, if the FIFO count is > DEPTH-2, the block SHALL drop the pair and increment drop_cnt, saturating at 0xFFFF.
REQ-016 The next FIFO count SHALL equal count + 2*push - pop; push and pop in the same cycle are both permitted, and the push decision SHALL ignore a same-cycle pop.
REQ-017 sig_ready SHALL equal (count >= 1) AND (NOT y_valid OR y_ready), with no dependence on sig_valid.
REQ-018 A transfer occurs when sig_valid AND sig_ready; on a transfer the block SHALL pop one noise sample n.
REQ-019 On a transfer, y_out SHALL be registered 1 cycle later as sat16(sig_in + floor((n * scale) / 2^15)), where n is signed 16-bit, scale is zero-extended, the product is exact (33-bit), and the shift is arithmetic.
REQ-020 sat16 SHALL clamp to the range [-32768, 32767].
REQ-021 On a transfer, y_valid SHALL be set to 1.
REQ-022 Without a transfer, y_valid SHALL be cleared when y_ready=1 and held otherwise.
REQ-023 While y_valid=1 and y_ready=0, y_out SHALL remain stable.
REQ-024 flush=1 SHALL set count to 0 next cycle and suppress both push and pop that cycle; it SHALL leave y_valid, y_out, the state and the counters unchanged.
REQ-025 With an empty FIFO the block SHALL hold sig_ready=0; an underflow SHALL never occur.

Reset
REQ-026 While reset=0, the block SHALL force y_out=0, y_valid=0, sig_ready=0, count=0, drop_cnt=0, sat_cnt=0, the warm-up counter to 0 and the state to WARM.
REQ-027 Assertion of reset during any transfer SHALL abort it, with no pending output retained.
REQ-028 The first push SHALL occur on cycle WARMUP+1 after reset release.

Configuration
REQ-029 With macro AWGN_SAT_CNT_EN defined, the block SHALL increment sat_cnt (saturating at 0xFFFF) on every transfer whose result was clamped.
REQ-030 Without AWGN_SAT_CNT_EN, sat_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-031 Reset release with x0=0x0010, x1=0x0020 held -> count stays 0 for 16 cycles, first push on cycle 17, count=2.
REQ-032 scale=0x4000, FIFO head n=2000, sig_in=1000 transfer -> y_out=2000 one cycle later, y_valid=1.
REQ-033 scale=0x4000, n=-3, sig_in=0 -> y_out=-2 (floor rounding).
REQ-034 scale=0x8000, n=1000, sig_in=32000 -> y_out=32767, and sat_cnt=1 with AWGN_SAT_CNT_EN defined, 0 without.
REQ-035 sig_valid=0 for 10 RUN cycles with DEPTH=8 -> count reaches 8, then drop_cnt increments by 1 per cycle.
REQ-036 y_ready=0 with y_valid=1 and sig_valid=1 -> sig_ready=0, y_out held; with y_ready=1 and sig_valid=1 -> back-to-back transfers, one per cycle; flush pulse -> count=0 next cycle, y_valid unchanged.
